// File: rtl/fixed_to_mxint_quantizer.sv
// rtl/fixed_to_mxint_quantizer.sv - three-stage fixed-point to MXINT block quantizer
//
// Converts one block of BLOCK_SIZE signed fixed-point elements per cycle into
// a shared signed exponent plus per-element signed mantissas.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   data_in_0[k]        fixed-point input elements, IN_FRAC_WIDTH fractional bits
//   data_in_0_valid     input beat valid
//   data_in_0_ready     input beat accepted when high together with valid
//   mdata_out_0[k]      output mantissas
//   edata_out_0         shared output exponent
//   data_out_0_valid    output beat valid
//   data_out_0_ready    downstream accepts the output beat
module fixed_to_mxint_quantizer #(
    parameter int BLOCK_SIZE    = 4,
    parameter int IN_WIDTH      = 16,
    parameter int IN_FRAC_WIDTH = 8,
    parameter int MAN_WIDTH     = 8,
    parameter int EXP_WIDTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  data_in_0 [BLOCK_SIZE],
    input  logic                 data_in_0_valid,
    output logic                 data_in_0_ready,
    output logic [MAN_WIDTH-1:0] mdata_out_0 [BLOCK_SIZE],
    output logic [EXP_WIDTH-1:0] edata_out_0,
    output logic                 data_out_0_valid,
    input  logic                 data_out_0_ready
);

    localparam int WW = $clog2(IN_WIDTH + 1);
    localparam int SW = $clog2((IN_WIDTH > MAN_WIDTH ? IN_WIDTH : MAN_WIDTH) + 1);
    localparam int XW = IN_WIDTH + MAN_WIDTH;

    // Every possible block exponent must be representable; no clamping exists.
    if ((-(2 ** (EXP_WIDTH - 1)) > -IN_FRAC_WIDTH) ||
        ((2 ** (EXP_WIDTH - 1)) - 1 < IN_WIDTH - 1 - IN_FRAC_WIDTH)) begin : g_exp_range_chk
        $error("EXP_WIDTH cannot represent the input exponent range");
    end

    // Stage state
    logic                 v1_q, v2_q, v3_q;
    logic [IN_WIDTH-1:0]  x1_q [BLOCK_SIZE];
    logic [WW-1:0]        w1_q [BLOCK_SIZE];
    logic [IN_WIDTH-1:0]  x2_q [BLOCK_SIZE];
    logic [EXP_WIDTH-1:0] e2_q;
    logic [SW-1:0]        sh2_q;
    logic                 right2_q;
    logic [MAN_WIDTH-1:0] m3_q [BLOCK_SIZE];
    logic [EXP_WIDTH-1:0] e3_q;

    // Next-state values
    logic [WW-1:0]        w_d [BLOCK_SIZE];
    logic [WW-1:0]        wmax_d;
    logic [EXP_WIDTH-1:0] e_d;
    logic [SW-1:0]        sh_d;
    logic                 right_d;
    logic [MAN_WIDTH-1:0] m_d [BLOCK_SIZE];

    logic adv1, adv2, adv3;

    // A stage may move when the stage after it moves or when it is empty.
    assign adv3 = data_out_0_ready | ~v3_q;
    assign adv2 = adv3 | ~v2_q;
    assign adv1 = adv2 | ~v1_q;
    assign data_in_0_ready = adv1;

    // S1: element width = position of the highest bit differing from the sign
    // bit, plus two; a value made only of sign bits needs a single bit.
    always_comb begin
        for (int k = 0; k < BLOCK_SIZE; k++) begin
            w_d[k] = WW'(1);
            for (int b = 0; b < IN_WIDTH - 1; b++) begin
                if (data_in_0[k][b] != data_in_0[k][IN_WIDTH-1]) begin
                    w_d[k] = WW'(b + 2);
                end
            end
        end
    end

    // S2: block width, exponent, and shift amount/direction.
    always_comb begin
        wmax_d = w1_q[0];
        for (int k = 1; k < BLOCK_SIZE; k++) begin
            if (w1_q[k] > wmax_d) begin
                wmax_d = w1_q[k];
            end
        end
        e_d     = EXP_WIDTH'(int'(wmax_d) - 1 - IN_FRAC_WIDTH);
        right_d = int'(wmax_d) > MAN_WIDTH;
        sh_d    = right_d ? SW'(int'(wmax_d) - MAN_WIDTH) : SW'(MAN_WIDTH - int'(wmax_d));
    end

    // S3: shift in a sign-extended working word so a narrow input can be
    // widened to a wider mantissa without losing the sign.
    always_comb begin
        logic [XW-1:0] ext;
        for (int k = 0; k < BLOCK_SIZE; k++) begin
            ext = {{MAN_WIDTH{x2_q[k][IN_WIDTH-1]}}, x2_q[k]};
            if (right2_q) begin
                ext = $signed(ext) >>> sh2_q;
            end else begin
                ext = ext << sh2_q;
            end
            m_d[k] = ext[MAN_WIDTH-1:0];
        end
    end

    // Valid bits and output registers: cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            e3_q <= '0;
            for (int k = 0; k < BLOCK_SIZE; k++) begin
                m3_q[k] <= '0;
            end
        end else begin
            if (adv1) v1_q <= data_in_0_valid;
            if (adv2) v2_q <= v1_q;
            if (adv3) v3_q <= v2_q;
            if (adv3 && v2_q) begin
                e3_q <= e2_q;
                m3_q <= m_d;
            end
        end
    end

    // Internal stage data: only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (adv1 && data_in_0_valid) begin
            x1_q <= data_in_0;
            w1_q <= w_d;
        end
        if (adv2 && v1_q) begin
            x2_q     <= x1_q;
            e2_q     <= e_d;
            sh2_q    <= sh_d;
            right2_q <= right_d;
        end
    end

    assign mdata_out_0      = m3_q;
    assign edata_out_0      = e3_q;
    assign data_out_0_valid = v3_q;

endmodule

// File: tb/tb_fixed_to_mxint_quantizer.sv
// tb/tb_fixed_to_mxint_quantizer.sv - self-checking bench for fixed_to_mxint_quantizer
module tb_fixed_to_mxint_quantizer;

    logic        clk;
    logic        rst;
    logic [15:0] din [4];
    logic        din_valid;
    logic        din_ready;
    logic [7:0]  mout [4];
    logic [3:0]  eout;
    logic        dout_valid;
    logic        dout_ready;

    fixed_to_mxint_quantizer dut (
        .clk             (clk),
        .rst             (rst),
        .data_in_0       (din),
        .data_in_0_valid (din_valid),
        .data_in_0_ready (din_ready),
        .mdata_out_0     (mout),
        .edata_out_0     (eout),
        .data_out_0_valid(dout_valid),
        .data_out_0_ready(dout_ready)
    );

    typedef struct {
        logic [35:0] d;
        int          cyc;
        bit          lat;
    } ent_t;

    ent_t        exp_q[$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    int          rdy_mode = 0;   // 0: ready high, 1: random, 2: ready low
    bit          lat_mode = 0;
    bit          stall_prev = 0;
    logic [36:0] prev_out;

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #1;
        dout_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // {e, m3, m2, m1, m0}
    function automatic logic [35:0] mk(input int e, input int m0, input int m1, input int m2, input int m3);
        return {4'(e), 8'(m3), 8'(m2), 8'(m1), 8'(m0)};
    endfunction

    // Reference: smallest two's complement width per element, block max,
    // then scale each value by a power of two (floor division when narrowing).
    function automatic logic [35:0] model(input logic [3:0][15:0] x);
        int v, w, wb, d, q;
        logic [35:0] r;
        wb = 1;
        for (int k = 0; k < 4; k++) begin
            v = int'($signed(x[k]));
            w = 1;
            while (!(v >= -(1 << (w - 1)) && v <= (1 << (w - 1)) - 1)) w++;
            if (w > wb) wb = w;
        end
        r[35:32] = 4'(wb - 1 - 8);
        for (int k = 0; k < 4; k++) begin
            v = int'($signed(x[k]));
            if (wb > 8) begin
                d = 1 << (wb - 8);
                q = v / d;
                if (v < 0 && (v % d) != 0) q = q - 1;
            end else begin
                q = v * (1 << (8 - wb));
            end
            r[8*k +: 8] = 8'(q);
        end
        return r;
    endfunction

    function automatic logic [3:0][15:0] blk(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [3:0][15:0] din_packed();
        logic [3:0][15:0] p;
        for (int k = 0; k < 4; k++) p[k] = din[k];
        return p;
    endfunction

    function automatic logic [35:0] dut_word();
        return {eout, mout[3], mout[2], mout[1], mout[0]};
    endfunction

    // Monitor/scoreboard: sample away from the rising edge.
    always @(negedge clk) begin
        ent_t ent;
        if (rst) begin
            exp_q.delete();
            stall_prev = 0;
        end else begin
            if (din_valid && din_ready) exp_q.push_back('{model(din_packed()), cyc, lat_mode});
            if (stall_prev) chk("stall_stable", {dout_valid, dut_word()}, prev_out);
            if (dout_valid && dout_ready) begin
                chk("unexpected_out", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    ent = exp_q.pop_front();
                    chk("out_data", dut_word(), ent.d);
                    if (ent.lat) chk("latency", cyc - ent.cyc, 3);
                end
            end
            stall_prev = dout_valid && !dout_ready;
            prev_out = {dout_valid, dut_word()};
        end
    end

    // Offer one beat and hold it until accepted; returns at posedge + 1.
    task automatic send(input logic [3:0][15:0] b);
        int n;
        n = 0;
        for (int k = 0; k < 4; k++) din[k] = b[k];
        din_valid = 1;
        forever begin
            @(negedge clk);
            if (din_ready) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        din_valid = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || dout_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][15:0] vec [6];
        logic [35:0]      lit [6];
        logic [3:0][15:0] fb [4];
        logic signed [15:0] t;
        logic [3:0][15:0] rb;
        int acc, idx, c0;

        vec[0] = blk(256, -128, 64, 0);      lit[0] = mk(1, 64, -32, 16, 0);
        vec[1] = blk(0, 0, 0, 0);            lit[1] = mk(-8, 0, 0, 0, 0);
        vec[2] = blk(-1, 0, 0, 0);           lit[2] = mk(-8, -128, 0, 0, 0);
        vec[3] = blk(1, 0, 0, 0);            lit[3] = mk(-7, 64, 0, 0, 0);
        vec[4] = blk(-32768, 32767, 257, -257); lit[4] = mk(7, -128, 127, 1, -2);
        vec[5] = blk(257, -257, 0, 0);       lit[5] = mk(1, 64, -65, 0, 0);
        for (int i = 0; i < 6; i++) chk($sformatf("model_pin%0d", i), model(vec[i]), lit[i]);

        din_valid = 0;
        for (int k = 0; k < 4; k++) din[k] = '0;
        rst = 0;
        #1 rst = 1;
        #2;
        chk("rst_valid", dout_valid, 0);
        chk("rst_out", dut_word(), 0);
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_ready", din_ready, 1);

        // Directed vectors at full rate with latency checks.
        lat_mode = 1;
        for (int i = 0; i < 6; i++) send(vec[i]);
        drain();

        // Sustained one beat per cycle with ready held high.
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) begin
                t = 16'($urandom);
                t = t >>> $urandom_range(0, 15);
                rb[k] = t;
            end
            send(rb);
        end
        chk("full_rate_cycles", cyc - c0, 8);
        drain();

        // Random blocks with random backpressure.
        lat_mode = 0;
        rdy_mode = 1;
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 4; k++) begin
                t = 16'($urandom);
                t = t >>> $urandom_range(0, 15);
                rb[k] = t;
            end
            send(rb);
        end
        rdy_mode = 0;
        drain();

        // Fill and stall: only three beats fit while the output is blocked.
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        fb[0] = blk(100, -3, 7, 0);
        fb[1] = blk(-500, 20, 1, 2);
        fb[2] = blk(3, 3, 3, -4);
        fb[3] = blk(32000, -1, 0, 9);
        acc = 0;
        idx = 0;
        for (int k = 0; k < 4; k++) din[k] = fb[0][k];
        din_valid = 1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (din_ready) begin
                acc++;
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx < 4) for (int k = 0; k < 4; k++) din[k] = fb[idx][k];
            else din_valid = 0;
        end
        chk("fill_accepted", acc, 3);
        chk("fill_ready_low", din_ready, 0);
        rdy_mode = 0;
        for (int c = 0; c < 50 && idx < 4; c++) begin
            @(negedge clk);
            if (din_ready) idx++;
            @(posedge clk);
            #1;
        end
        din_valid = 0;
        chk("fill_fourth", idx, 4);
        drain();

        // Asynchronous reset with three beats in flight.
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send(blk(1000, 2, 3, 4));
        send(blk(-7, 8, 9, 10));
        send(blk(11, -12, 13, 14));
        chk("inflight_valid", dout_valid, 1);
        #2 rst = 1;
        #1;
        chk("async_rst_valid", dout_valid, 0);
        chk("async_rst_out", dut_word(), 0);
        @(posedge clk);
        #1 rst = 0;
        chk("post_rst_ready", din_ready, 1);
        rdy_mode = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("no_stale", dout_valid, 0);
        end
        @(posedge clk);
        #1;
        lat_mode = 1;
        send(blk(-200, 45, 0, 1));
        drain();

        chk("final_queue", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
